// File: rtl/imem_sync.sv
// Instruction memory with a power-up NOP fill sequence, registered fetch port
// and a byte-lane program-write port with write-first forwarding to fetch.
module imem_sync #(
  parameter int unsigned NUM_INST = 128,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic        busy,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  input  logic [3:0]  prog_be
);

  localparam int unsigned IDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;

  typedef enum logic {
    FILL,
    READY
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic              busy_q, busy_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [31:0]       mem [NUM_INST];

  logic [IDX_W-1:0]  f_idx;
  logic              f_fault;
  logic [IDX_W-1:0]  p_idx;
  logic              p_ok;
  logic [31:0]       p_word;
  logic [31:0]       rd_word;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;
  logic              unused_prog_lsb;

  assign f_idx           = pc[IDX_W+1:2];
  assign f_fault         = (pc[1:0] != 2'b00) || (|pc[31:IDX_W+2]);
  assign p_idx           = prog_addr[IDX_W+1:2];
  assign p_ok            = ~|prog_addr[31:IDX_W+2];
  assign unused_prog_lsb = ^prog_addr[1:0];

  // Merged program word feeds both the array write and the same-word fetch bypass.
  always_comb begin
    p_word = mem[p_idx];
    for (int unsigned k = 0; k < 4; k++) begin
      if (prog_be[k]) p_word[8*k +: 8] = prog_data[8*k +: 8];
    end
    rd_word = mem[f_idx];
    if (prog_we && p_ok && (p_idx == f_idx)) rd_word = p_word;
  end

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    busy_d     = busy_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    mem_we     = 1'b0;
    mem_waddr  = fill_idx_q;
    mem_wdata  = NOP_INST;
    unique case (state_q)
      FILL: begin
        mem_we     = 1'b1;
        fill_idx_d = fill_idx_q + IDX_W'(1);
        if (fill_idx_q == '1) begin
          state_d = READY;
          busy_d  = 1'b0;
        end
      end
      READY: begin
        if (prog_we && p_ok) begin
          mem_we    = 1'b1;
          mem_waddr = p_idx;
          mem_wdata = p_word;
        end
        if (!stall) begin
          if (fetch_req) begin
            valid_d = 1'b1;
            fault_d = f_fault;
            instr_d = f_fault ? NOP_INST : rd_word;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_idx_q <= '0;
      busy_q     <= 1'b1;
      instr_q    <= NOP_INST;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      busy_q     <= busy_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: fill timing, fetch, byte-lane programming,
// faults, stall/hold behaviour and reset during READY.
module tb_imem_sync;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        fetch_req;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic        busy;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic [3:0]  prog_be;

  int checks = 0;
  int errors = 0;
  int n;

  imem_sync #(.NUM_INST(128), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .busy        (busy),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_be     (prog_be)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges until busy drops; instr_valid must stay low meanwhile.
  task automatic wait_fill(output int cnt);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      cnt++;
      if (!busy) break;
      chk("fill_valid_low", {31'b0, instr_valid}, 32'h0);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    pc        = a;
    fetch_req = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b1; pc = '0; fetch_req = 1'b0; stall = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_be = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy",  {31'b0, busy}, 32'h1);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    repeat (2) cyc();
    chk("rst_hold_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b1;

    wait_fill(n);
    chk("fill_cycles", n, 32'd128);

    for (int i = 0; i < 128; i++) begin
      fetch(32'(i * 4));
      chk("fill_nop_instr", instr, NOP);
      chk("fill_nop_fault", {31'b0, fetch_fault}, 32'h0);
    end
    chk("fill_nop_valid", {31'b0, instr_valid}, 32'h1);
    fetch_req = 1'b0;

    // Full-word program then fetch
    prog_we = 1'b1; prog_addr = 32'd8; prog_data = 32'h0062A023; prog_be = 4'hF;
    cyc();
    prog_we = 1'b0;
    fetch(32'd8);
    chk("prog_instr", instr, 32'h0062A023);
    chk("prog_valid", {31'b0, instr_valid}, 32'h1);

    // Same-cycle partial write and fetch: write-first merge
    prog_we = 1'b1; prog_addr = 32'd8; prog_data = 32'h1234AA56; prog_be = 4'b0010;
    fetch(32'd8);
    chk("wf_instr", instr, 32'h0062AA23);
    prog_we = 1'b0;

    // Low address bits ignored on program writes
    prog_we = 1'b1; prog_addr = 32'd11; prog_data = 32'hCCDDEE77; prog_be = 4'b0001;
    fetch_req = 1'b0;
    cyc();
    prog_we = 1'b0;
    fetch(32'd8);
    chk("lsb_ign_instr", instr, 32'h0062AA77);

    // Out-of-range write dropped (would alias word 0 if truncated)
    prog_we = 1'b1; prog_addr = 32'd512; prog_data = 32'hDEADBEEF; prog_be = 4'hF;
    fetch_req = 1'b0;
    cyc();
    prog_we = 1'b0;
    fetch(32'd0);
    chk("oor_wr_instr", instr, NOP);

    // Faulting fetches
    fetch(32'd6);
    chk("mis_instr", instr, NOP);
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    chk("mis_valid", {31'b0, instr_valid}, 32'h1);
    fetch(32'd512);
    chk("oor_instr", instr, NOP);
    chk("oor_fault", {31'b0, fetch_fault}, 32'h1);
    fetch(32'd0);
    chk("clr_fault", {31'b0, fetch_fault}, 32'h0);
    chk("clr_instr", instr, NOP);

    // Stall holds outputs while pc moves
    fetch(32'd8);
    chk("pre_stall_instr", instr, 32'h0062AA77);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4 + 6);
      cyc();
      chk("stall_instr", instr, 32'h0062AA77);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_fault", {31'b0, fetch_fault}, 32'h0);
    end
    stall = 1'b0; fetch_req = 1'b0;
    cyc();
    chk("idle_valid", {31'b0, instr_valid}, 32'h0);
    chk("idle_instr", instr, 32'h0062AA77);

    // Program word 5, then reset mid-READY
    prog_we = 1'b1; prog_addr = 32'd20; prog_data = 32'h11223344; prog_be = 4'hF;
    cyc();
    prog_we = 1'b0;
    fetch(32'd20);
    chk("w5_instr", instr, 32'h11223344);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'b0, busy}, 32'h1);
    chk("mid_rst_instr", instr, NOP);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("mid_rst_fault", {31'b0, fetch_fault}, 32'h0);
    cyc();
    rst_n = 1'b1;
    // Requests during refill must be ignored
    fetch_req = 1'b1; pc = 32'd20;
    prog_we = 1'b1; prog_addr = 32'd20; prog_data = 32'hFFFFFFFF; prog_be = 4'hF;
    wait_fill(n);
    prog_we = 1'b0;
    chk("refill_cycles", n, 32'd128);
    fetch(32'd20);
    chk("refill_instr", instr, NOP);
    chk("refill_fault", {31'b0, fetch_fault}, 32'h0);
    fetch_req = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
